// File: rtl/addatone_pkg.sv
// Shared constants and state encoding for the additive-synthesis harmonic loop.
package addatone_pkg;
  localparam int PHASE_W   = 16;
  localparam int HARMONICS = 32;
  localparam int ADDR_W    = 5;
  localparam int NYQUIST   = 2 ** (PHASE_W - 1);

  typedef enum logic [1:0] {CLEAR, FETCH, CALC, READY} state_t;
endpackage

// File: rtl/harmonic_phase_ram.sv
// Simple dual-port phase store: synchronous write, registered read (1-cycle latency).
module harmonic_phase_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              fpga_clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge fpga_clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/harmonic_phase_accumulator.sv
// Per-harmonic phase store: presents a harmonic's phase and advances it by
// (harmonic+1)*frequency on each consumer acknowledge.
module harmonic_phase_accumulator
  import addatone_pkg::*;
#(
  parameter int HARMONICS = addatone_pkg::HARMONICS,
  parameter int ADDR_W    = addatone_pkg::ADDR_W,
  parameter int PHASE_W   = addatone_pkg::PHASE_W
) (
  input  logic               fpga_clock,
  input  logic               reset,
  input  logic [PHASE_W-1:0] frequency,
  input  logic [7:0]         harmonic,
  input  logic               next_sample,
  output logic               sample_ready,
  output logic [PHASE_W-1:0] sample_position,
  output logic               above_nyquist
);
  localparam int INCR_W = 24;
  localparam logic [INCR_W-1:0] NYQ_THRESH = INCR_W'(2 ** (PHASE_W - 1));

  function automatic logic is_above_nyquist(input logic [INCR_W-1:0] incr);
    return incr >= NYQ_THRESH;
  endfunction

  function automatic logic [PHASE_W-1:0] wrap_add(input logic [PHASE_W-1:0] pos,
                                                  input logic [INCR_W-1:0]  incr);
    return pos + incr[PHASE_W-1:0];
  endfunction

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [7:0]          h_reg;
  logic [PHASE_W-1:0]  freq_latched, freq_src, rd_data, next_pos, wr_data;
  logic [INCR_W-1:0]   incr_full;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wr_en;
  logic                h_in_range;

  assign h_in_range = (32'(h_reg) < 32'(HARMONICS));
  // A harmonic-0 fetch uses the frequency it is latching in the same cycle.
  assign freq_src   = (harmonic == 8'd0) ? frequency : freq_latched;

  harmonic_phase_ram #(
    .DEPTH  (HARMONICS),
    .ADDR_W (ADDR_W),
    .DATA_W (PHASE_W)
  ) u_ram (
    .fpga_clock (fpga_clock),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (harmonic[ADDR_W-1:0]),
    .rd_data    (rd_data)
  );

  always_ff @(posedge fpga_clock) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = clr_cnt;
    wr_data   = '0;
    case (state)
      CLEAR: begin
        wr_en = 1'b1;
        if (clr_cnt == ADDR_W'(HARMONICS - 1)) state_nxt = FETCH;
      end
      FETCH: state_nxt = CALC;
      CALC:  state_nxt = READY;
      READY: begin
        if (next_sample) begin
          state_nxt = FETCH;
          wr_en     = h_in_range;
          wr_addr   = h_reg[ADDR_W-1:0];
          wr_data   = next_pos;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      clr_cnt         <= '0;
      freq_latched    <= '0;
      sample_ready    <= 1'b0;
      sample_position <= '0;
      above_nyquist   <= 1'b0;
    end else begin
      if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      if (state == FETCH && harmonic == 8'd0) freq_latched <= frequency;
      if (state == CALC) begin
        sample_ready    <= 1'b1;
        sample_position <= h_in_range ? rd_data : '0;
        above_nyquist   <= !h_in_range || is_above_nyquist(incr_full);
      end else if (state == READY && next_sample) begin
        sample_ready <= 1'b0;
      end
    end
  end

  // FETCH -> CALC boundary: harmonic index and its increment
  always_ff @(posedge fpga_clock) begin
    if (state == FETCH) begin
      h_reg     <= harmonic;
      incr_full <= INCR_W'({1'b0, harmonic} + 9'd1) * INCR_W'(freq_src);
    end
    // CALC -> READY boundary: advanced phase awaiting commit
    if (state == CALC) next_pos <= wrap_add(rd_data, incr_full);
  end
endmodule
